// File: rtl/frame_pkg.sv
// Shared constants and writer state type for the ping-pong frame loader.
package frame_pkg;
    localparam int SIZE_DEF  = 16;
    localparam int PIX_W_DEF = 8;
    localparam int CW        = $clog2(SIZE_DEF);

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_e;
endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: simple dual-port RAM, synchronous write, registered read.
module frame_bank_ram
    import frame_pkg::*;
#(
    parameter int DEPTH = SIZE_DEF * SIZE_DEF,
    parameter int WIDTH = PIX_W_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_loader.sv
// Ping-pong frame buffer: fills one SIZExSIZE bank from a raster stream while
// the other is read by the anti-aliasing stage.
//   state  | meaning
//   W_IDLE | waiting for s_sof; other pixels are dropped and counted
//   W_FILL | writing pixels of a frame in raster order
module frame_loader
    import frame_pkg::*;
#(
    parameter int SIZE     = SIZE_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    localparam int ROW_W   = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    output logic             frame_valid,
    input  logic             frame_done,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [ROW_W-1:0] rd_col,
    output logic [PIX_W-1:0] rd_data,
    output logic             sof_err,
    output logic [7:0]       drop_cnt
);

    wr_state_e          state, state_nxt;
    logic               wr_bank, rd_bank, rd_sel;
    logic [1:0]         full, full_nxt;
    logic [ROW_W-1:0]   wr_row, wr_col, row_nxt, col_nxt;
    logic [2*ROW_W-1:0] wr_addr, rd_addr;
    logic               accept, wr_en, set_full, release_bank;
    logic               sof_err_nxt, drop_inc, last_pix;
    logic [PIX_W-1:0]   q0, q1;

    assign s_ready      = !full[wr_bank] && !reset;
    assign accept       = s_valid && s_ready;
    assign frame_valid  = full[rd_bank];
    assign release_bank = frame_done && full[rd_bank];
    assign last_pix     = (wr_row == '1) && (wr_col == '1);
    assign rd_addr      = {rd_row, rd_col};

    always_comb begin
        state_nxt   = state;
        row_nxt     = wr_row;
        col_nxt     = wr_col;
        wr_en       = 1'b0;
        wr_addr     = {wr_row, wr_col};
        set_full    = 1'b0;
        sof_err_nxt = 1'b0;
        drop_inc    = 1'b0;
        if (accept) begin
            if (s_sof) begin
                // A start-of-frame always restarts at (0,0), mid-frame or not.
                wr_en       = 1'b1;
                wr_addr     = '0;
                row_nxt     = '0;
                col_nxt     = ROW_W'(1);
                state_nxt   = W_FILL;
                sof_err_nxt = (state == W_FILL);
            end else if (state == W_IDLE) begin
                drop_inc = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (last_pix) begin
                    set_full  = 1'b1;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    state_nxt = W_IDLE;
                end else begin
                    col_nxt = wr_col + ROW_W'(1);
                    if (wr_col == '1) begin
                        row_nxt = wr_row + ROW_W'(1);
                    end
                end
            end
        end
    end

    // Set and release never hit the same bank, so both may apply together.
    always_comb begin
        full_nxt = full;
        if (set_full) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (release_bank) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= W_IDLE;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rd_sel   <= 1'b0;
            full     <= 2'b00;
            wr_row   <= '0;
            wr_col   <= '0;
            sof_err  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            wr_row  <= row_nxt;
            wr_col  <= col_nxt;
            full    <= full_nxt;
            sof_err <= sof_err_nxt;
            rd_sel  <= rd_bank;
            if (set_full) begin
                wr_bank <= ~wr_bank;
            end
            if (release_bank) begin
                rd_bank <= ~rd_bank;
            end
            if (drop_inc && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    frame_bank_ram #(.DEPTH(SIZE * SIZE), .WIDTH(PIX_W)) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && !wr_bank),
        .waddr (wr_addr),
        .wdata (s_data),
        .raddr (rd_addr),
        .rdata (q0)
    );

    frame_bank_ram #(.DEPTH(SIZE * SIZE), .WIDTH(PIX_W)) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && wr_bank),
        .waddr (wr_addr),
        .wdata (s_data),
        .raddr (rd_addr),
        .rdata (q1)
    );

    assign rd_data = rd_sel ? q1 : q0;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader against a frame-level reference model.
module tb_frame_loader;

    logic       clk = 1'b0;
    logic       reset, s_valid, s_sof, frame_done;
    logic       s_ready, frame_valid, sof_err;
    logic [7:0] s_data, rd_data, drop_cnt;
    logic [3:0] rd_row, rd_col;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: two banks of 256 pixels indexed by raster position.
    bit [7:0] m_mem [2][256];
    bit [1:0] m_full;
    bit       m_wr, m_rd, m_fill, m_sof_err;
    int       m_idx, m_drop;
    bit       rd_chk;
    bit [7:0] rd_exp;

    always #5 clk = ~clk;

    frame_loader #(.SIZE(16), .PIX_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .frame_valid (frame_valid),
        .frame_done  (frame_done),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .sof_err     (sof_err),
        .drop_cnt    (drop_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict, clock, compare.
    task automatic cyc(input bit v, input bit [7:0] d, input bit sof, input bit done,
                       input bit rst, input bit [3:0] rr, input bit [3:0] rc, output bit acc);
        bit       ready, rel, chk_n;
        bit [7:0] exp_n;
        s_valid = v; s_data = d; s_sof = sof; frame_done = done; reset = rst;
        rd_row = rr; rd_col = rc;
        #1;
        ready = !rst && !m_full[m_wr];
        check_val("s_ready", s_ready, ready);
        acc   = v && ready;
        rel   = !rst && done && m_full[m_rd];
        chk_n = !rst && m_full[m_rd];
        exp_n = m_mem[m_rd][{rr, rc}];
        @(posedge clk);
        if (rst) begin
            m_full = 2'b00; m_wr = 0; m_rd = 0; m_fill = 0; m_idx = 0;
            m_drop = 0; m_sof_err = 0;
            chk_n = 1; exp_n = 8'd0;
        end else begin
            m_sof_err = 0;
            if (acc) begin
                if (sof) begin
                    m_sof_err = m_fill;
                    m_mem[m_wr][0] = d;
                    m_idx = 1;
                    m_fill = 1;
                end else if (!m_fill) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_mem[m_wr][m_idx] = d;
                    if (m_idx == 255) begin
                        m_full[m_wr] = 1;
                        m_wr = !m_wr;
                        m_fill = 0;
                        m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            if (rel) begin
                m_full[m_rd] = 0;
                m_rd = !m_rd;
            end
        end
        rd_chk = chk_n;
        rd_exp = exp_n;
        @(negedge clk);
        check_val("frame_valid", frame_valid, m_full[m_rd]);
        check_val("sof_err", sof_err, m_sof_err);
        check_val("drop_cnt", drop_cnt, m_drop);
        if (rd_chk) check_val("rd_data", rd_data, rd_exp);
    endtask

    task automatic idle(input int n, input bit done);
        bit acc;
        for (int i = 0; i < n; i++)
            cyc(0, 8'($urandom), 0, done, 0, 4'($urandom), 4'($urandom), acc);
    endtask

    task automatic send_pix(input bit [7:0] d, input bit sof, input bit done, input bit gaps);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc && tries < 600) begin
            if (gaps && ($urandom % 6 == 0)) idle(1, 0);
            cyc(1, d, sof, done && (tries == 0), 0, 4'($urandom), 4'($urandom), acc);
            tries++;
        end
        if (!acc) check_val("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int n, input bit ramp, input bit gaps);
        for (int i = 0; i < n; i++)
            send_pix(ramp ? 8'(i) : 8'($urandom), i == 0, 0, gaps);
    endtask

    task automatic read_at(input bit [3:0] r, input bit [3:0] c, input bit [7:0] exp, input string tag);
        bit acc;
        cyc(0, 8'd0, 0, 0, 0, r, c, acc);
        check_val(tag, rd_data, exp);
    endtask

    initial begin
        bit acc;
        int pc;
        s_valid = 0; s_data = 0; s_sof = 0; frame_done = 0; reset = 1;
        rd_row = 0; rd_col = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 1, 0, 0, acc);
        cyc(0, 0, 0, 0, 1, 0, 0, acc);
        check_val("rst_frame_valid", frame_valid, 0);
        check_val("rst_rd_data", rd_data, 0);

        // Frame A: ramp pattern, back-to-back pixels.
        send_frame(256, 1, 0);
        check_val("fv_after_A", frame_valid, 1);
        read_at(4'd3, 4'd5, 8'd53, "rd_3_5");

        // Frame B with no release: both banks full.
        send_frame(256, 0, 1);
        idle(1, 0);
        check_val("ready_both_full", s_ready, 0);
        idle(1, 1);
        check_val("fv_B", frame_valid, 1);
        check_val("ready_after_done", s_ready, 1);
        idle(30, 0);
        idle(1, 1);

        // Drops before start-of-frame, then saturation.
        for (int i = 0; i < 10; i++) send_pix(8'($urandom), 0, 0, 0);
        check_val("drop_10", drop_cnt, 10);
        send_frame(256, 0, 1);
        idle(20, 0);
        idle(1, 1);
        for (int i = 0; i < 300; i++) send_pix(8'($urandom), 0, 0, 1);
        check_val("drop_sat", drop_cnt, 255);

        // Restart mid-frame at pixel 100.
        send_frame(100, 0, 0);
        send_pix(8'hA5, 1, 0, 0);
        check_val("sof_err_pulse", sof_err, 1);
        for (int i = 1; i < 256; i++) send_pix(8'($urandom), 0, 0, 0);
        check_val("fv_restart", frame_valid, 1);
        read_at(4'd0, 4'd0, 8'hA5, "rd_restart_00");
        idle(20, 0);

        // Last pixel of the next frame together with the release of this one.
        send_frame(255, 0, 0);
        send_pix(8'($urandom), 0, 1, 0);
        check_val("fv_simul", frame_valid, 1);
        idle(20, 0);
        idle(1, 1);
        check_val("fv_after_release", frame_valid, 0);

        // Reset in the middle of a frame while another bank is full.
        send_frame(256, 0, 0);
        send_frame(40, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, acc);
        check_val("rst_mid_fv", frame_valid, 0);
        check_val("rst_mid_drop", drop_cnt, 0);
        send_frame(256, 1, 1);
        read_at(4'd15, 4'd15, 8'd255, "rd_after_rst");
        idle(10, 1);

        // Randomized traffic with occasional restarts, releases and resets.
        pc = 0;
        for (int k = 0; k < 5000; k++) begin
            bit rst_r, sof_r;
            rst_r = ($urandom % 2500 == 0);
            sof_r = (pc == 0) || ($urandom % 600 == 0);
            cyc($urandom % 4 != 0, 8'($urandom), sof_r, $urandom % 48 == 0, rst_r,
                4'($urandom), 4'($urandom), acc);
            if (rst_r) pc = 0;
            else if (acc) pc = sof_r ? 1 : ((pc + 1) % 256);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_loader.md
# frame_loader

Ping-pong frame buffer directly upstream of the anti-aliasing stage. It accepts a raster-order pixel stream with valid/ready handshake and fills one of two SIZE×SIZE banks. A completed bank is presented to the anti-aliasing stage through a registered random-access read port. The downstream stage releases the bank with a done pulse, so capture of frame N+1 overlaps processing of frame N.

## Interface
Parameters:
- SIZE, 16: frame width and height in pixels; power of two, ≥4.
- PIX_W, 8: pixel bit width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  loader can accept a pixel.
- s_data  in  PIX_W  pixel value.
- s_sof  in  1  pixel is (row 0, col 0) of a frame.
- frame_valid  out  1  bank rd_bank holds a complete frame.
- frame_done  in  1  one-cycle pulse from downstream; releases rd_bank.
- rd_row  in  CW  read row, CW = $clog2(SIZE).
- rd_col  in  CW  read column.
- rd_data  out  PIX_W  pixel at (rd_row, rd_col) of rd_bank, 1-cycle latency.
- sof_err  out  1  one-cycle pulse: s_sof seen mid-frame.
- drop_cnt  out  8  saturating count of pixels discarded while waiting for s_sof.

## Operation
- State: wr_bank, rd_bank (1 bit each), full[1:0], wr_row/wr_col (CW bits), writer FSM {W_IDLE, W_FILL}.
- s_ready = !full[wr_bank] && !reset. A pixel is accepted when s_valid && s_ready.
- W_IDLE:
  - Accepted pixel with s_sof=0 is discarded; drop_cnt increments, saturating at 255.
  - Accepted pixel with s_sof=1 is written at (0,0); next position is (0,1); go to W_FILL.
- W_FILL:
  - Each accepted pixel is written at (wr_row, wr_col). wr_col wraps SIZE-1→0 and increments wr_row.
  - Accepted pixel with s_sof=1 restarts the frame: write at (0,0), next position (0,1), pulse sof_err. Bank contents are not cleared.
  - Accepted pixel at (SIZE-1, SIZE-1): set full[wr_bank], toggle wr_bank, go to W_IDLE.
- Reader:
  - frame_valid = full[rd_bank].
  - frame_done while frame_valid: clear full[rd_bank], toggle rd_bank.
  - frame_done while !frame_valid is ignored.
- Simultaneous last-pixel write and frame_done always address different banks and both take effect in that cycle. The writer never targets a full bank, so wr_bank≠rd_bank whenever full[rd_bank]=1.
- Both banks full: s_ready=0 until a frame_done.
- rd_data reads bank rd_bank as sampled at the address cycle. Reads of a non-full bank return the stale contents; the downstream stage only reads while frame_valid.

## Timing
- Reset values:
  - Outputs: s_ready=0 during reset, 1 the first cycle after. frame_valid=0, rd_data=0, sof_err=0, drop_cnt=0.
  - Internal: wr_bank=rd_bank=0, full=0, W_IDLE.
  - Memory contents are not reset.
- Reset mid-frame abandons the partial frame and any full banks.
- Write latency: frame_valid rises the cycle after the last pixel is accepted.
- Release latency: frame_valid reflects the next bank the cycle after frame_done.
- Read latency: rd_data is valid exactly one cycle after rd_row/rd_col are presented. Throughput is one read per cycle.
- Input throughput is one pixel per cycle while s_ready=1. s_ready does not depend combinationally on s_valid.

## Structure
- Package frame_pkg:
  - SIZE and PIX_W defaults.
  - CW localparam.
  - Writer state enum {W_IDLE, W_FILL}.
- Sub-module frame_bank_ram, instantiated twice:
  - SIZE*SIZE × PIX_W.
  - One synchronous write port, one synchronous read port, address {row, col}.
- rd_data is a mux of the two RAM outputs, selected by registered rd_bank.

## Test plan
- Reset, then stream 256 pixels (SIZE=16) with s_data=row*16+col and s_sof on the first → frame_valid=1 the next cycle; rd_row=3, rd_col=5 gives rd_data=53 one cycle later.
- Stream frames A and B with no frame_done → s_ready=0 after B's last pixel. Pulse frame_done → frame_valid stays 1 with B's data and s_ready returns to 1.
- 10 pixels without s_sof, then a full frame → drop_cnt=10 and the frame loads correctly; 300 dropped pixels → drop_cnt=255.
- s_sof at pixel index 100 of a frame → sof_err pulses once; the frame completes 256 pixels after the restart, and (0,0) holds the restart pixel.
- Last pixel of frame B accepted in the same cycle as frame_done for frame A → frame_valid stays 1, rd_bank=B, full=2'b10 or 2'b01 accordingly; no frame is lost.
- Assert reset mid-frame at pixel 40 → frame_valid=0 and drop_cnt=0; the next full frame loads into bank 0.
